// File: rtl/npc_pkg.sv
// Shared definitions for the load/store path.
//   DATA_WIDTH / NUM_LANES : datapath width and byte-lane count (32-bit only)
//   F3_*                   : RV32I load/store width/sign encodings
//   state_e                : mem_access_unit FSM states
//   mem_op_t               : one latched memory op
//   f3_illegal()           : funct3 values the unit refuses (faults without bus access)
package npc_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_LANES  = DATA_WIDTH / 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wen;
    logic [2:0]            funct3;
  } mem_op_t;

  // Unsigned widths only exist for loads; 011/110/111 are never valid.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic wen);
    return (f3 != F3_LB) && (f3 != F3_LH) && (f3 != F3_LW) &&
           (f3 != F3_LBU) && (f3 != F3_LHU) ||
           (wen && f3[2]);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the memory (slave).
//   mem_req_valid/mem_req_ready : request handshake; addr/wen/wdata/wstrb are the payload
//   mem_resp_valid              : load data or store acknowledge, with mem_rdata/mem_resp_err
interface mem_access_unit_if;
  import npc_pkg::*;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_LANES-1:0]  mem_wstrb;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_resp_err;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the load/store unit.
//   addr_lo, funct3, wen : op descriptor (low address bits, width/sign, store flag)
//   wdata                : raw store data (rs2)
//   rdata                : raw word from memory
//   fault                : op must not reach the bus (illegal funct3, or misaligned
//                          when MISALIGN_TRAP_EN is defined)
//   st_wdata, st_wstrb   : lane-replicated store data and byte enables (0 for loads)
//   ld_data              : selected and extended load data (0 for stores)
// Misaligned ops that are not trapped are naturally aligned by dropping the
// offending low address bits.
module lsu_align
  import npc_pkg::*;
(
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] st_wdata,
  output logic [NUM_LANES-1:0]  st_wstrb,
  output logic [DATA_WIDTH-1:0] ld_data
);
  logic [1:0]                 size, off;
  logic                       sgn;
  logic [NUM_LANES-1:0][7:0]  wl, rl;
  logic [7:0]                 ld_b;
  logic [15:0]                ld_h;

  assign size = funct3[1:0];
  assign sgn  = ~funct3[2];

  // Byte offset after natural alignment.
  always_comb begin
    case (size)
      2'b00:   off = addr_lo;
      2'b01:   off = {addr_lo[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wl[i] = (size == 2'b00) ? wdata[7:0] :
                   (size == 2'b01) ? wdata[8*(i%2) +: 8] : wdata[8*i +: 8];
    assign st_wstrb[i] = wen && ((size == 2'b00) ? (off == 2'(i)) :
                                 (size == 2'b01) ? (off[1] == 1'(i/2)) : 1'b1);
  end

  assign st_wdata = wen ? wl : '0;

  assign rl   = rdata;
  assign ld_b = rl[off];
  assign ld_h = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_data = '0;
    if (!wen) begin
      case (size)
        2'b00:   ld_data = {{24{sgn & ld_b[7]}}, ld_b};
        2'b01:   ld_data = {{16{sgn & ld_h[15]}}, ld_h};
        default: ld_data = rdata;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign fault = f3_illegal(funct3, wen) ||
                 ((size == 2'b01) && addr_lo[0]) ||
                 ((size == 2'b10) && (addr_lo != 2'b00));
`else
  assign fault = f3_illegal(funct3, wen);
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: accepts one op from execute, runs a single valid/ready
// transaction on the data-memory bus and returns one result to write-back.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   req_valid/req_ready           : op handshake (ready only in IDLE, low in reset)
//   req_addr/wdata/wen/funct3     : effective address, store data, store flag, width
//   resp_valid/resp_rdata/resp_err: one-cycle completion pulse with result
//   mem (mem_access_unit_if.master): data-memory bus
// Build option: MISALIGN_TRAP_EN -- misaligned halves/words fault instead of being
// naturally aligned.
module mem_access_unit
  import npc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  mem_access_unit_if.master     mem
);
  state_e                state_q, state_d;
  mem_op_t               op_q;
  logic                  idle, accept, fault, in_req;
  logic [1:0]            al_addr_lo;
  logic [2:0]            al_funct3;
  logic                  al_wen;
  logic [DATA_WIDTH-1:0] al_wdata, st_wdata, ld_data, rdata_q;
  logic [NUM_LANES-1:0]  st_wstrb;
  logic                  err_q;

  assign idle      = (state_q == IDLE);
  assign req_ready = rst_n && idle;
  assign accept    = req_valid && req_ready;
  assign in_req    = (state_q == REQ);

  // In IDLE the aligner judges the incoming op (fault decision at accept);
  // afterwards it steers the latched op.
  assign al_addr_lo = idle ? req_addr[1:0] : op_q.addr[1:0];
  assign al_funct3  = idle ? req_funct3    : op_q.funct3;
  assign al_wen     = idle ? req_wen       : op_q.wen;
  assign al_wdata   = idle ? req_wdata     : op_q.wdata;

  lsu_align u_align (
    .addr_lo  (al_addr_lo),
    .funct3   (al_funct3),
    .wen      (al_wen),
    .wdata    (al_wdata),
    .rdata    (mem.mem_rdata),
    .fault    (fault),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = fault ? DONE : REQ;
      REQ:     if (mem.mem_req_ready) state_d = WAIT;
      WAIT:    if (mem.mem_resp_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)
        op_q <= '{addr: req_addr, wdata: req_wdata, wen: req_wen, funct3: req_funct3};
      if (accept && fault) begin
        err_q <= 1'b1;
      end else if ((state_q == WAIT) && mem.mem_resp_valid) begin
        rdata_q <= ld_data;
        err_q   <= mem.mem_resp_err;
      end else if (state_q == DONE) begin
        // result is only visible in DONE; clear for the next IDLE
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign resp_valid = (state_q == DONE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Payload is driven only while requesting so the bus idles at zero.
  assign mem.mem_req_valid = in_req;
  assign mem.mem_addr      = in_req ? {op_q.addr[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem.mem_wen       = in_req && op_q.wen;
  assign mem.mem_wdata     = in_req ? st_wdata : '0;
  assign mem.mem_wstrb     = in_req ? st_wstrb : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import npc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_wen = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wen    (req_wen),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what the bus and write-back should see for one op, from the
  // width/offset rules expressed with plain arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic w,
                                input logic [2:0] f3, input logic [31:0] rd,
                                output logic fault, output logic [31:0] maddr,
                                output logic [31:0] mwdata, output logic [3:0] mstrb,
                                output logic [31:0] ldv);
    int nb, off;
    logic [31:0] mask;
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    fault = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (w && f3[2]);
`ifdef MISALIGN_TRAP_EN
    if (int'(a % 4) % nb != 0) fault = 1'b1;
`endif
    off    = (int'(a % 4) / nb) * nb;
    maddr  = a - (a % 4);
    mwdata = '0;
    for (int b = 0; b < 4; b++)
      mwdata |= ((d >> (8 * (b % nb))) & 32'hFF) << (8 * b);
    mstrb = w ? 4'(((1 << nb) - 1) << off) : 4'b0000;
    mask  = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
    ldv   = (rd >> (8 * off)) & mask;
    if (!f3[2] && nb < 4 && ldv[8*nb-1]) ldv |= ~mask;
  endfunction

  // Issue one op; the memory accepts after rdy_dly stalled cycles and answers
  // rsp_dly cycles after the handshake cycle's successor.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [2:0] f3, input int rdy_dly,
                        input int rsp_dly, input logic [31:0] rd, input logic rerr);
    logic        fault;
    logic [31:0] ea, ew, el;
    logic [3:0]  es;
    model(a, d, w, f3, rd, fault, ea, ew, es, el);
    @(negedge clk);
    chk({tag, "/req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_wen = w; req_funct3 = f3;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    if (fault) begin
      chk({tag, "/flt_mem_req_valid"}, bus.mem_req_valid, 0);
      chk({tag, "/flt_resp_valid"}, resp_valid, 1);
      chk({tag, "/flt_resp_err"}, resp_err, 1);
      chk({tag, "/flt_resp_rdata"}, resp_rdata, 0);
    end else begin
      for (int n = 0; n <= rdy_dly; n++) begin
        chk({tag, "/mem_req_valid"}, bus.mem_req_valid, 1);
        chk({tag, "/resp_valid_req"}, resp_valid, 0);
        chk({tag, "/mem_addr"}, bus.mem_addr, ea);
        chk({tag, "/mem_wen"}, bus.mem_wen, w);
        chk({tag, "/mem_wstrb"}, bus.mem_wstrb, es);
        if (w) chk({tag, "/mem_wdata"}, bus.mem_wdata, ew);
        bus.mem_req_ready = (n == rdy_dly);
        @(negedge clk);
      end
      bus.mem_req_ready = 1'b0;
      for (int n = 0; n <= rsp_dly; n++) begin
        chk({tag, "/mem_req_valid_wait"}, bus.mem_req_valid, 0);
        chk({tag, "/resp_valid_wait"}, resp_valid, 0);
        bus.mem_resp_valid = (n == rsp_dly);
        bus.mem_rdata      = (n == rsp_dly) ? rd : $urandom;
        bus.mem_resp_err   = (n == rsp_dly) ? rerr : 1'b0;
        @(negedge clk);
      end
      bus.mem_resp_valid = 1'b0; bus.mem_resp_err = 1'b0;
      chk({tag, "/resp_valid"}, resp_valid, 1);
      chk({tag, "/resp_err"}, resp_err, rerr);
      chk({tag, "/resp_rdata"}, resp_rdata, w ? 32'h0 : el);
    end
    @(negedge clk);
    chk({tag, "/post_resp_valid"}, resp_valid, 0);
    chk({tag, "/post_resp_rdata"}, resp_rdata, 0);
    chk({tag, "/post_resp_err"}, resp_err, 0);
    chk({tag, "/post_req_ready"}, req_ready, 1);
  endtask

  initial begin
    logic [2:0] legal_f3 [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    bus.mem_rdata = '0; bus.mem_resp_err = 1'b0;

    // reset state
    #12;
    chk("rst/req_ready", req_ready, 0);
    chk("rst/resp_valid", resp_valid, 0);
    chk("rst/resp_rdata", resp_rdata, 0);
    chk("rst/mem_req_valid", bus.mem_req_valid, 0);
    chk("rst/mem_addr", bus.mem_addr, 0);
    chk("rst/mem_wstrb", bus.mem_wstrb, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst/req_ready_after", req_ready, 1);

    // directed cases
    run_op("sw",  32'h8000_0004, 32'hDEAD_BEEF, 1'b1, F3_LW,  0, 0, 32'h0, 1'b0);
    run_op("lb",  32'h8000_0003, 32'h0,         1'b0, F3_LB,  0, 0, 32'h80FF_1234, 1'b0);
    run_op("lbu", 32'h8000_0003, 32'h0,         1'b0, F3_LBU, 0, 0, 32'h80FF_1234, 1'b0);
    run_op("sh",  32'h0000_0002, 32'h0000_ABCD, 1'b1, F3_LH,  5, 0, 32'h0, 1'b0);
    run_op("lw_mis", 32'h0000_0006, 32'h0,      1'b0, F3_LW,  0, 1, 32'h1357_9BDF, 1'b0);
    run_op("lh_mis", 32'h0000_0013, 32'h0,      1'b0, F3_LH,  1, 0, 32'hC001_7002, 1'b0);
    run_op("f3_011", 32'h0000_0010, 32'h0,      1'b0, 3'b011, 0, 0, 32'h0, 1'b0);
    run_op("sbu_ill", 32'h0000_0010, 32'h55,    1'b1, F3_LBU, 0, 0, 32'h0, 1'b0);
    run_op("lh_err", 32'h0000_0000, 32'h0,      1'b0, F3_LH,  0, 2, 32'h1234_8001, 1'b1);
    run_op("sb3", 32'h0000_0103, 32'h1122_3344, 1'b1, F3_LB,  2, 1, 32'h0, 1'b0);

    // reset while waiting for the memory response
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0100; req_wen = 1'b0; req_funct3 = F3_LW;
    @(negedge clk);
    req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    chk("rstw/mem_req_valid", bus.mem_req_valid, 1);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("rstw/in_wait", bus.mem_req_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw/req_ready", req_ready, 0);
    chk("rstw/resp_valid", resp_valid, 0);
    chk("rstw/resp_rdata", resp_rdata, 0);
    chk("rstw/resp_err", resp_err, 0);
    chk("rstw/mem_req_valid", bus.mem_req_valid, 0);
    chk("rstw/mem_addr", bus.mem_addr, 0);
    chk("rstw/mem_wen", bus.mem_wen, 0);
    chk("rstw/mem_wdata", bus.mem_wdata, 0);
    chk("rstw/mem_wstrb", bus.mem_wstrb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D; bus.mem_resp_err = 1'b1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0; bus.mem_resp_err = 1'b0;
    chk("rstw/late_resp_valid", resp_valid, 0);
    chk("rstw/late_req_ready", req_ready, 1);
    @(negedge clk);
    chk("rstw/late_resp_valid2", resp_valid, 0);

    // randomized ops, with occasional stray responses while idle
    for (int k = 0; k < 80; k++) begin
      logic [2:0] f3;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = $urandom;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        chk("rnd/stray_resp", resp_valid, 0);
      end
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                        : legal_f3[$urandom_range(0, 4)];
      run_op("rnd", $urandom, $urandom, 1'($urandom_range(0, 1)), f3,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
             ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
